alarm_controller: RTL and testbench
===================================

// Module: alarm_controller
// PURPOSE
//  Arming/disarming FSM of the alarm system. Conditions the raw sensor and push-buttons,
//  applies exit/entry delays and a code check, and drives alarm_out. alarm_out feeds
//  the aux input of the downstream LED blinker stage (1 = blink, 0 = LED off).
//  Single clock domain (clk); all board inputs arrive asynchronous.
// PARAMETERS
//  CODE_W      4           width of code switches
//  CODE        4'hA        disarm/arm code, compared against code_sw
//  DEB_CYC     50_000      cycles an input must be stable before debounced value changes (1 ms @50 MHz)
//  EXIT_CYC    500_000_000 exit delay, cycles from arm to ARMED (10 s @50 MHz)
//  ENTRY_CYC   500_000_000 entry delay, cycles from sensor trip to ALARM
//  MAX_FAIL    3           consecutive wrong disarm codes that force ALARM (1..3)
// PORTS
//  clk         in   1       system clock, 50 MHz
//  rst         in   1       synchronous, active-high reset
//  sensor_in   in   1       raw door/PIR sensor, 1 = tripped, asynchronous
//  btn_arm     in   1       raw arm push-button, 1 = pressed, asynchronous
//  btn_disarm  in   1       raw disarm push-button, 1 = pressed, asynchronous
//  code_sw     in   CODE_W  code switches, sampled when a button press is accepted
//  alarm_out   out  1       1 while in ALARM; connects to LED blinker aux
//  armed       out  1       1 in ARMED or ENTRY_DLY
//  state_o     out  3       current FSM state encoding (debug/7-seg)
//  fail_cnt    out  2       consecutive wrong disarm attempts
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=DISARMED, timer=0, fail_cnt=0, sync/debounce regs=0,
//   alarm_out=0, armed=0, state_o=3'd0. Reset mid-delay or mid-ALARM aborts immediately.
//  Conditioning per input: 2-flop synchronizer -> debouncer (counter of DEB_CYC, restart on
//   any change; output updates when count reaches DEB_CYC-1) -> rising-edge detect giving
//   1-cycle pulses arm_p, disarm_p. Sensor uses level sensor_db, no edge detect.
//  Latency raw edge -> pulse: 2 (sync) + DEB_CYC (debounce) + 1 (edge) cycles; FSM acts
//   on the pulse cycle; outputs are Moore (decoded from state reg), visible next cycle.
//  code_ok = (code_sw == CODE), evaluated in the pulse cycle.
//  States (state_o): DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4.
//   DISARMED : arm_p & code_ok -> EXIT_DLY, timer<=EXIT_CYC-1; arm_p & !code_ok -> stay.
//   EXIT_DLY : disarm_p & code_ok -> DISARMED; timer==0 -> ARMED; else timer--.
//   ARMED    : sensor_db -> ENTRY_DLY, timer<=ENTRY_CYC-1.
//   ENTRY_DLY: timer==0 -> ALARM; else timer--.
//   ALARM    : stays until disarm_p & code_ok; sensor ignored.
//   In EXIT_DLY/ARMED/ENTRY_DLY/ALARM: disarm_p & code_ok -> DISARMED, fail_cnt<=0;
//    disarm_p & !code_ok -> fail_cnt++ (saturating); reaching MAX_FAIL -> ALARM at once.
//  fail_cnt clears on any correct-code accept and on entry to DISARMED.
//  Simultaneous arm_p & disarm_p: disarm processed, arm ignored.
//  Disarm with correct code in the same cycle timer hits 0 -> DISARMED (disarm wins).
//  Sensor already tripped at entry to ARMED -> ENTRY_DLY on the first ARMED cycle.
//  Timer width $clog2(max(EXIT_CYC,ENTRY_CYC)); down-counter, never wraps below 0.
//  arm_p outside DISARMED ignored. Unused state encodings -> DISARMED.
// STRUCTURE
//  alarm_pkg: state typedef/localparams (DISARMED..ALARM), STATE_W=3.
//  Sub-module: input_debouncer (sync + debounce + optional rise pulse), instantiated x3.
// TESTING (bench params DEB_CYC=4, EXIT_CYC=8, ENTRY_CYC=8, CODE=4'hA, MAX_FAIL=3)
//  1. rst 1 cycle -> alarm_out=0, armed=0, state_o=0, fail_cnt=0.
//  2. code_sw=A, press arm 10 cyc -> state_o=1 after ~7 cyc, state_o=2 8 cyc later, armed=1.
//  3. ARMED, sensor_in=1 held -> state_o=3, 8 cyc later state_o=4, alarm_out=1; disarm A -> 0, alarm_out=0.
//  4. ARMED, 3 disarm presses with code 5 -> fail_cnt 1,2, then state_o=4 on third.
//  5. Sensor glitch 2 cyc wide in ARMED -> state stays 2 (debounce rejects).
//  6. ENTRY_DLY, rst pulse -> next cycle state_o=0, alarm_out=0, timer reloads only on re-arm.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding and helpers for the alarm controller.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED  = 3'd0,
        ST_EXIT_DLY  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ENTRY_DLY = 3'd3,
        ST_ALARM     = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus stability-counter debouncer for one raw board input.
// EDGE_EN selects a one-cycle rising-edge pulse output instead of the debounced level.
module input_debouncer #(
    parameter int DEB_CYC = 50_000,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sig_o
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the held value.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        if (EDGE_EN) begin : g_rise
            logic dly_q;
            always_ff @(posedge clk) begin
                if (rst) dly_q <= 1'b0;
                else     dly_q <= db_q;
            end
            assign sig_o = db_q & ~dly_q;
        end else begin : g_level
            assign sig_o = db_q;
        end
    endgenerate

endmodule

// File: rtl/alarm_controller.sv
// Alarm arming FSM: conditioned sensor/buttons, exit and entry delays, code check,
// and a consecutive wrong-code counter that can force the alarm.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int                CODE_W    = 4,
    parameter logic [CODE_W-1:0] CODE      = 4'hA,
    parameter int                DEB_CYC   = 50_000,
    parameter int                EXIT_CYC  = 500_000_000,
    parameter int                ENTRY_CYC = 500_000_000,
    parameter int                MAX_FAIL  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_in,
    input  logic              btn_arm,
    input  logic              btn_disarm,
    input  logic [CODE_W-1:0] code_sw,
    output logic              alarm_out,
    output logic              armed,
    output logic [2:0]        state_o,
    output logic [1:0]        fail_cnt
);

    localparam int TIMER_W = max_int($clog2(max_int(EXIT_CYC, ENTRY_CYC)), 1);
    localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYC - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYC - 1);

    logic [2:0] raw_in;
    logic [2:0] cond;
    logic       sensor_db, arm_p, disarm_p;

    assign raw_in = {btn_disarm, btn_arm, sensor_in};

    // Bit 0 (sensor) stays a level; the two buttons become rising-edge pulses.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_in
            input_debouncer #(
                .DEB_CYC (DEB_CYC),
                .EDGE_EN (gi != 0)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .din   (raw_in[gi]),
                .sig_o (cond[gi])
            );
        end
    endgenerate

    assign sensor_db = cond[0];
    assign arm_p     = cond[1];
    assign disarm_p  = cond[2];

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           fail_q, fail_d, fail_inc;
    logic                 alarm_q, armed_q;
    logic                 code_ok, disarm_ok, disarm_bad;

    assign code_ok    = (code_sw == CODE);
    assign disarm_ok  = disarm_p & code_ok;
    assign disarm_bad = disarm_p & ~code_ok;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

        case (state_q)
            ST_DISARMED: begin
                fail_d = '0;
                if (arm_p && code_ok && !disarm_p) begin
                    state_d = ST_EXIT_DLY;
                    timer_d = EXIT_LOAD;
                end
            end
            ST_EXIT_DLY: begin
                if (timer_q == '0) state_d = ST_ARMED;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ST_ARMED: begin
                if (sensor_db) begin
                    state_d = ST_ENTRY_DLY;
                    timer_d = ENTRY_LOAD;
                end
            end
            ST_ENTRY_DLY: begin
                if (timer_q == '0) state_d = ST_ALARM;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ST_ALARM: ;
            default: begin
                state_d = ST_DISARMED;
                timer_d = '0;
                fail_d  = '0;
            end
        endcase

        // Disarm handling overrides any timer expiry or sensor event in the same cycle.
        if (state_q inside {ST_EXIT_DLY, ST_ARMED, ST_ENTRY_DLY, ST_ALARM}) begin
            if (disarm_ok) begin
                state_d = ST_DISARMED;
                timer_d = '0;
                fail_d  = '0;
            end else if (disarm_bad) begin
                fail_d = fail_inc;
                if (int'(fail_inc) >= MAX_FAIL) state_d = ST_ALARM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DISARMED;
            timer_q <= '0;
            fail_q  <= '0;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            alarm_q <= (state_d == ST_ALARM);
            armed_q <= (state_d == ST_ARMED) || (state_d == ST_ENTRY_DLY);
        end
    end

    assign alarm_out = alarm_q;
    assign armed     = armed_q;
    assign state_o   = state_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed plus randomized bench for alarm_controller with a transaction-level reference model.
module tb_alarm_controller;

    localparam int         DEB_CYC   = 4;
    localparam int         EXIT_CYC  = 8;
    localparam int         ENTRY_CYC = 8;
    localparam int         MAX_FAIL  = 3;
    localparam logic [3:0] CODE      = 4'hA;
    localparam int         PRESS_LAT = 2 + DEB_CYC + 1;

    localparam int S_DIS = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3, S_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst, sensor_in, btn_arm, btn_disarm;
    logic [3:0] code_sw;
    logic       alarm_out, armed;
    logic [2:0] state_o;
    logic [1:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int m_state = S_DIS;
    int m_fail  = 0;

    alarm_controller #(
        .CODE_W    (4),
        .CODE      (CODE),
        .DEB_CYC   (DEB_CYC),
        .EXIT_CYC  (EXIT_CYC),
        .ENTRY_CYC (ENTRY_CYC),
        .MAX_FAIL  (MAX_FAIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_in  (sensor_in),
        .btn_arm    (btn_arm),
        .btn_disarm (btn_disarm),
        .code_sw    (code_sw),
        .alarm_out  (alarm_out),
        .armed      (armed),
        .state_o    (state_o),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        $display("[TB] %s: state=%0d fail=%0d alarm=%0b armed=%0b", tag, state_o, fail_cnt, alarm_out, armed);
        chk({tag, ".state"}, 32'(state_o), 32'(m_state));
        chk({tag, ".fail"},  32'(fail_cnt), 32'(m_fail));
        chk({tag, ".alarm"}, 32'(alarm_out), 32'(m_state == S_ALARM));
        chk({tag, ".armed"}, 32'(armed), 32'((m_state == S_ARMED) || (m_state == S_ENTRY)));
    endtask

    task automatic wait_state(input int tgt, input int budget, output int n);
        n = 0;
        while (state_o !== 3'(tgt) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", 32'(state_o), 32'(tgt));
    endtask

    // Reference rule for an accepted disarm press with code c.
    function automatic void model_disarm(input logic [3:0] c);
        if (m_state != S_DIS) begin
            if (c == CODE) begin
                m_state = S_DIS;
                m_fail  = 0;
            end else begin
                m_fail = (m_fail < 3) ? m_fail + 1 : 3;
                if (m_fail >= MAX_FAIL) m_state = S_ALARM;
            end
        end
    endfunction

    task automatic do_arm(input logic [3:0] c);
        int n;
        code_sw = c;
        btn_arm = 1'b1;
        if (c == CODE && m_state == S_DIS) begin
            wait_state(S_EXIT, PRESS_LAT + 5, n);
            chk("arm_latency", 32'(n), 32'(PRESS_LAT));
            wait_state(S_ARMED, EXIT_CYC + 4, n);
            chk("exit_delay", 32'(n), 32'(EXIT_CYC));
            m_state = S_ARMED;
            m_fail  = 0;
        end else begin
            cyc(PRESS_LAT + 5);
        end
        btn_arm = 1'b0;
        cyc(DEB_CYC + 4);
        check_all($sformatf("arm code=%h", c));
    endtask

    task automatic do_disarm(input logic [3:0] c);
        code_sw    = c;
        btn_disarm = 1'b1;
        cyc(PRESS_LAT + 3);
        btn_disarm = 1'b0;
        cyc(DEB_CYC + 4);
        model_disarm(c);
        check_all($sformatf("disarm code=%h", c));
    endtask

    task automatic do_trip();
        int n;
        sensor_in = 1'b1;
        wait_state(S_ENTRY, PRESS_LAT + 5, n);
        chk("entry_latency", 32'(n), 32'(PRESS_LAT));
        chk("entry_armed", 32'(armed), 32'd1);
        wait_state(S_ALARM, ENTRY_CYC + 4, n);
        chk("entry_delay", 32'(n), 32'(ENTRY_CYC));
        m_state   = S_ALARM;
        sensor_in = 1'b0;
        cyc(DEB_CYC + 4);
        check_all("trip");
    endtask

    task automatic do_glitch(input int w);
        sensor_in = 1'b1;
        cyc(w);
        sensor_in = 1'b0;
        cyc(DEB_CYC + 6);
        check_all($sformatf("glitch w=%0d", w));
    endtask

    initial begin
        int n;
        int r;
        logic [3:0] c;

        rst = 1'b1; sensor_in = 1'b0; btn_arm = 1'b0; btn_disarm = 1'b0; code_sw = 4'h0;
        cyc(2);
        rst = 1'b0;
        check_all("reset");

        do_arm(CODE);
        do_trip();
        do_disarm(CODE);

        do_arm(CODE);
        do_disarm(4'h5);
        do_disarm(4'h5);
        do_disarm(4'h5);
        do_disarm(4'h7);
        do_disarm(CODE);

        do_arm(CODE);
        for (int i = 1; i < DEB_CYC; i++) do_glitch(i);
        do_disarm(CODE);

        // Simultaneous arm and disarm: disarm is taken, arm ignored.
        code_sw = CODE; btn_arm = 1'b1; btn_disarm = 1'b1;
        cyc(PRESS_LAT + 5);
        btn_arm = 1'b0; btn_disarm = 1'b0;
        cyc(DEB_CYC + 4);
        check_all("arm_and_disarm");

        // Correct disarm during the exit delay aborts arming.
        code_sw = CODE; btn_arm = 1'b1;
        wait_state(S_EXIT, PRESS_LAT + 5, n);
        btn_arm = 1'b0; btn_disarm = 1'b1;
        cyc(PRESS_LAT + 3);
        check_all("exit_abort");
        btn_disarm = 1'b0;
        cyc(DEB_CYC + 4);
        check_all("exit_abort_idle");

        // Sensor already tripped when ARMED is reached, then reset mid entry delay.
        sensor_in = 1'b1; code_sw = CODE; btn_arm = 1'b1;
        wait_state(S_EXIT, PRESS_LAT + 5, n);
        wait_state(S_ARMED, EXIT_CYC + 4, n);
        chk("pretrip_exit_delay", 32'(n), 32'(EXIT_CYC));
        cyc(1);
        chk("pretrip_entry", 32'(state_o), 32'(S_ENTRY));
        btn_arm = 1'b0;
        cyc(3);
        chk("pretrip_hold", 32'(state_o), 32'(S_ENTRY));
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        m_state = S_DIS; m_fail = 0;
        check_all("reset_in_entry");
        cyc(ENTRY_CYC + 4);
        check_all("post_reset_idle");
        sensor_in = 1'b0;
        cyc(DEB_CYC + 4);

        do_arm(4'h3);

        for (int i = 0; i < 30; i++) begin
            c = ($urandom_range(0, 2) == 0) ? CODE : 4'($urandom_range(0, 15));
            if (m_state == S_DIS) begin
                do_arm(c);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)                           do_disarm(c);
                else if (r < 8 || m_state != S_ARMED) do_glitch($urandom_range(1, DEB_CYC - 1));
                else                                  do_trip();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
